// File: rtl/regfile_2r1w_clr_if.sv
// ============================================================================
// Module      : regfile_2r1w_clr_if
// Description : Bus bundle for regfile_2r1w_clr: write port, two read ports
//               and the bulk-clear handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_2r1w_clr_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              wr_accept;
    logic [ADDR_W-1:0] raddr0;
    logic [WIDTH-1:0]  rdata0;
    logic [ADDR_W-1:0] raddr1;
    logic [WIDTH-1:0]  rdata1;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;

    modport master (
        output we, waddr, wdata, raddr0, raddr1, clear_req,
        input  wr_accept, rdata0, rdata1, clear_busy, clear_done
    );

    modport slave (
        input  we, waddr, wdata, raddr0, raddr1, clear_req,
        output wr_accept, rdata0, rdata1, clear_busy, clear_done
    );
endinterface

`default_nettype wire

// File: rtl/regfile_2r1w_clr.sv
// ============================================================================
// Module      : regfile_2r1w_clr
// Description : Parametrised 2-read/1-write register file with registered
//               reads and a one-entry-per-cycle bulk-clear engine.
//               Define REGFILE_WR_BYPASS_EN for write-first read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w_clr #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  wire logic          CLK,
    input  wire logic          ASYNCRESET,
    regfile_2r1w_clr_if.slave  bus
);
    localparam int                c_idx_w     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_clearing;
    logic              w_wr_accept;

    assign w_clearing     = (r_state == ST_CLEAR);
    assign w_wr_accept    = bus.we & ~w_clearing & ({1'b0, bus.waddr} < c_depth_ext);
    assign bus.wr_accept  = w_wr_accept;
    assign bus.clear_busy = w_clearing;
    assign bus.clear_done = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clear_req)     w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_cnt == c_last)   w_state_nxt = ST_DONE;
            ST_DONE:                         w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter sits at 0 outside CLEAR and saturates at the last entry.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_clearing)
                r_cnt <= '0;
            else if (r_cnt != c_last)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_clearing) begin
            r_mem[r_cnt[c_idx_w-1:0]] <= '0;
        end else if (w_wr_accept) begin
            r_mem[bus.waddr[c_idx_w-1:0]] <= bus.wdata;
        end
    end

    logic [ADDR_W-1:0] w_raddr [2];
    assign w_raddr[0] = bus.raddr0;
    assign w_raddr[1] = bus.raddr1;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic             w_in_range;
        logic             w_fwd;
        logic [WIDTH-1:0] r_rdata;

        assign w_in_range = ({1'b0, w_raddr[p]} < c_depth_ext);
`ifdef REGFILE_WR_BYPASS_EN
        // wr_accept is already low during CLEAR, so clear writes never forward.
        assign w_fwd = w_wr_accept & (w_raddr[p] == bus.waddr);
`else
        assign w_fwd = 1'b0;
`endif

        always_ff @(posedge CLK or posedge ASYNCRESET) begin
            if (ASYNCRESET)
                r_rdata <= '0;
            else if (w_fwd)
                r_rdata <= bus.wdata;
            else if (w_in_range)
                r_rdata <= r_mem[w_raddr[p][c_idx_w-1:0]];
            else
                r_rdata <= '0;
        end
    end

    assign bus.rdata0 = g_rd_port[0].r_rdata;
    assign bus.rdata1 = g_rd_port[1].r_rdata;

endmodule

`default_nettype wire

// File: doc/regfile_2r1w_clr.md
Name: regfile_2r1w_clr

Overview:
- Parametrised register file: one write port, two registered read ports.
- Adds a sequenced bulk-clear engine (one entry per cycle) with a busy/done handshake.
- Generalises the fixed two-register file (reg0/reg1) in the register_file group to arbitrary width and depth.
- Sits beside the datapath as the architectural register store.

Parameters:
- WIDTH, 16, data bits per entry (>=1)
- DEPTH, 4, number of entries (>=2, need not be a power of two)
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- CLK  input  1  clock; all state updates on rising edge
- ASYNCRESET  input  1  asynchronous active-high reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- wr_accept  output  1  combinational; we & ~clear_busy & (waddr < DEPTH)
- raddr0  input  ADDR_W  read address, port 0
- rdata0  output  WIDTH  registered read data, port 0
- raddr1  input  ADDR_W  read address, port 1
- rdata1  output  WIDTH  registered read data, port 1
- clear_req  input  1  request bulk clear (sampled in IDLE only)
- clear_busy  output  1  high while clear engine runs
- clear_done  output  1  one-cycle pulse after last entry cleared

Behaviour:
- Interface: one clock CLK; reset ASYNCRESET is asynchronous and active-high.
- Reset (asserts immediately, independent of CLK):
  - all entries = 0; rdata0 = rdata1 = 0
  - FSM = IDLE, clear counter = 0; clear_busy = 0, clear_done = 0
- Write:
  - On the edge where wr_accept = 1, mem[waddr] <= wdata.
  - waddr >= DEPTH: write dropped, wr_accept = 0.
- Read, latency 1:
  - On every edge, rdataN <= mem[raddrN].
  - raddrN >= DEPTH gives 0.
  - Both ports may address the same entry.
  - Read and write to the same address on the same edge: rdata gets the OLD contents (see optional feature).
- Clear FSM states:
  - IDLE: clear_busy = 0. clear_req = 1 -> CLEAR, cnt <= 0.
  - CLEAR: clear_busy = 1. Each edge: mem[cnt] <= 0, cnt <= cnt + 1. When cnt == DEPTH-1 -> DONE.
  - DONE: clear_busy = 0, clear_done = 1 for exactly one cycle -> IDLE unconditionally.
  - Total: DEPTH cycles busy + 1 done cycle. clear_req is ignored outside IDLE; level-held clear_req re-triggers from IDLE after DONE.
- During CLEAR:
  - external writes are not performed; wr_accept = 0
  - reads continue and return current contents, so entries at index < cnt read 0
- clear_req and we both high in IDLE on the same edge: the write is performed on that edge; CLEAR starts next cycle and will zero it.
- cnt is ADDR_W bits; no wrap beyond DEPTH-1.
- ASYNCRESET mid-CLEAR: aborts to IDLE with all entries 0; no clear_done pulse.
- Outputs clear_busy and clear_done are decoded from the state register (glitch-free, Moore).

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN
- Defined:
  - If wr_accept = 1 and raddrN == waddr on an edge, rdataN <= wdata (write-first forwarding), per port independently.
  - No forwarding during CLEAR (clear writes are not bypassed).
- Undefined:
  - Read-first: rdataN gets pre-write contents; new value visible one cycle later.

Test Plan (WIDTH=8, DEPTH=4, ADDR_W=2 unless noted):
1. Reset then read all addresses -> rdata0/rdata1 = 0x00, clear_busy = 0, clear_done = 0.
2. Write 0xA5@1, 0x3C@2, then raddr0=1, raddr1=2 -> next cycle rdata0 = 0xA5, rdata1 = 0x3C; both ports at addr 2 -> both 0x3C.
3. Same-edge write 0x77@3 with raddr0=3 (entry holding 0x11):
   - macro undefined -> rdata0 = 0x11, then 0x77 a cycle later
   - macro defined -> rdata0 = 0x77 immediately
4. Fill 1,2,3,4 then pulse clear_req:
   - clear_busy high exactly 4 cycles, then clear_done one cycle
   - we=1 of 0xFF@0 during busy -> wr_accept = 0
   - afterwards all entries read 0x00
5. Assert ASYNCRESET between clock edges during CLEAR with cnt=2:
   - clear_busy drops immediately; no clear_done; all reads 0
6. DEPTH=3, ADDR_W=2: write 0x5A to addr 3 -> wr_accept = 0, no entry changed; raddr0=3 -> rdata0 = 0x00.
